// File: rtl/multi_cycle_control.sv
// multi_cycle_control: IF/ID/EXE/MEM/WB sequencer for the multi-cycle MIPS datapath.
// Outputs are purely combinational from state, opcode, funct and zero.
module multi_cycle_control #(
    parameter int          ADDR_W  = 2,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic              zero,
    output logic [2:0]        state,
    output logic              PCWre,
    output logic              IRWre,
    output logic              ALUSrcA,
    output logic              ALUSrcB,
    output logic [3:0]        ALUOp,
    output logic              ExtSel,
    output logic              RegWre,
    output logic [1:0]        RegDst,
    output logic              WrRegDSrc,
    output logic              DBDataSrc,
    output logic              mRD,
    output logic              mWR,
    output logic [ADDR_W-1:0] PCSrc
);
    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b111
    } state_t;

    state_t cur, nxt;
    logic r_type, i_add, i_sub, i_and, i_or, i_slt, i_sll, i_jr;
    logic i_addi, i_ori, i_lw, i_sw, i_beq, i_bne, i_j, i_jal, i_halt;
    logic known, id_final, ex;
    logic [3:0] alu_op;

    assign state  = cur;
    assign r_type = opcode == 6'b000000;
    assign i_add  = r_type && funct == 6'b100000;
    assign i_sub  = r_type && funct == 6'b100010;
    assign i_and  = r_type && funct == 6'b100100;
    assign i_or   = r_type && funct == 6'b100101;
    assign i_slt  = r_type && funct == 6'b101010;
    assign i_sll  = r_type && funct == 6'b000000;
    assign i_jr   = r_type && funct == 6'b001000;
    assign i_addi = opcode == 6'b001000;
    assign i_ori  = opcode == 6'b001101;
    assign i_lw   = opcode == 6'b100011;
    assign i_sw   = opcode == 6'b101011;
    assign i_beq  = opcode == 6'b000100;
    assign i_bne  = opcode == 6'b000101;
    assign i_j    = opcode == 6'b000010;
    assign i_jal  = opcode == 6'b000011;
    assign i_halt = opcode == HALT_OP;

    assign known = i_add | i_sub | i_and | i_or | i_slt | i_sll | i_jr | i_addi | i_ori |
                   i_lw | i_sw | i_beq | i_bne | i_j | i_jal;
    // Jumps and undecoded opcodes retire in ID; undecoded ones behave as a NOP.
    assign id_final = i_j | i_jal | i_jr | !known;
    // ALU controls stay driven from EXE through WB so the datapath result holds.
    assign ex = cur == S_EXE || cur == S_MEM || cur == S_WB;

    assign alu_op = (i_sub | i_beq | i_bne) ? 4'b0001 :
                    i_sll                   ? 4'b0010 :
                    (i_or | i_ori)          ? 4'b0011 :
                    i_and                   ? 4'b0100 :
                    i_slt                   ? 4'b0101 : 4'b0000;

    always_ff @(posedge CLK or negedge Reset)
        if (!Reset) cur <= S_IF;
        else        cur <= nxt;

    always_comb begin
        nxt       = cur;
        PCWre     = 1'b0;
        IRWre     = cur == S_IF;
        ALUSrcA   = ex && i_sll;
        ALUSrcB   = ex && (i_addi | i_ori | i_lw | i_sw);
        ALUOp     = ex ? alu_op : 4'b0000;
        ExtSel    = ex && !i_ori;
        RegWre    = 1'b0;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b1;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        PCSrc     = '0;
        case (cur)
            S_IF: nxt = S_ID;
            S_ID: begin
                if (i_halt) nxt = S_HALT;
                else if (id_final) begin
                    nxt       = S_IF;
                    PCWre     = 1'b1;
                    PCSrc     = (i_j | i_jal) ? ADDR_W'(2'b11) : i_jr ? ADDR_W'(2'b10) : '0;
                    RegWre    = i_jal;
                    RegDst    = i_jal ? 2'b10 : 2'b00;
                    WrRegDSrc = !i_jal;
                end
                else nxt = S_EXE;
            end
            S_EXE: begin
                if (i_beq | i_bne) begin
                    nxt   = S_IF;
                    PCWre = 1'b1;
                    PCSrc = ((i_beq && zero) || (i_bne && !zero)) ? ADDR_W'(2'b01) : '0;
                end
                else nxt = (i_lw | i_sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mRD   = i_lw;
                mWR   = i_sw;
                PCWre = i_sw;
                nxt   = i_sw ? S_IF : S_WB;
            end
            S_WB: begin
                nxt       = S_IF;
                PCWre     = 1'b1;
                RegWre    = 1'b1;
                RegDst    = r_type ? 2'b01 : 2'b00;
                DBDataSrc = i_lw;
            end
            S_HALT: nxt = S_HALT;
            default: nxt = S_IF;
        endcase
    end
endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Multi-cycle control unit for the MIPS CPU: the driving end of the ALU control interface.
- Sequences each instruction through IF/ID/EXE/MEM/WB.
- Drives ALUSrcA, ALUSrcB and ALUOp into the ALU, and consumes the ALU zero flag to resolve branches.
- Also drives PC, instruction-register, register-file and data-memory enables for the datapath.

Parameters:
- ADDR_W, 2, width of the PCSrc mux select.
- HALT_OP, 6'b111111, opcode that parks the FSM in HALT.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction[31:26], taken from the IR.
- funct  in  6  instruction[5:0], taken from the IR.
- zero  in  1  ALU zero flag (result==0).
- state  out  3  current state: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111.
- PCWre  out  1  PC load enable.
- IRWre  out  1  IR load enable.
- ALUSrcA  out  1  0=ReadData1, 1=sa (shift amount).
- ALUSrcB  out  1  0=ReadData2, 1=extend.
- ALUOp  out  4  0000 ADD, 0001 SUB, 0010 SLL (B<<A), 0011 OR, 0100 AND, 0101 SLT (signed).
- ExtSel  out  1  1=sign-extend imm16, 0=zero-extend.
- RegWre  out  1  register-file write enable.
- RegDst  out  2  00=rt, 01=rd, 10=$31.
- WrRegDSrc  out  1  0=PC+4 (jal), 1=DBData.
- DBDataSrc  out  1  0=ALU result, 1=memory read data.
- mRD  out  1  data-memory read.
- mWR  out  1  data-memory write.
- PCSrc  out  ADDR_W  00=PC+4, 01=PC+4+(sext<<2), 10=rs (jr), 11=jump target.

Behaviour:
- State register: sampled on the CLK rising edge. Reset low forces state=IF immediately, asynchronously, even mid-instruction.
- All outputs are combinational from state, opcode, funct and zero.
- Reset values (state=IF): IRWre=1; PCWre=0; RegWre=mWR=mRD=0; ALUSrcA=ALUSrcB=0; ALUOp=0000; PCSrc=00; RegDst=00; WrRegDSrc=1; DBDataSrc=0; ExtSel=0.
- Default for every state: all write enables 0. IRWre=1 only in IF.
- Decoded set:
  - R-type (op 000000): add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, jr 001000.
  - Immediate and memory: addi 001000, ori 001101, lw 100011, sw 101011.
  - Branch and jump: beq 000100, bne 000101, j 000010, jal 000011.
  - halt = HALT_OP.
- Transitions:
  - IF -> ID.
  - ID -> IF for j, jal, jr and undecoded opcodes; ID -> HALT for halt; else ID -> EXE.
  - EXE -> IF for beq/bne; EXE -> MEM for lw/sw; else EXE -> WB.
  - MEM -> WB for lw; MEM -> IF for sw.
  - WB -> IF.
  - HALT -> HALT until Reset.
- PCWre is asserted for exactly one cycle, in the final state of each instruction: ID (j/jal/jr/undecoded), EXE (beq/bne), MEM (sw), WB (others). Never asserted in HALT.
- ID state:
  - j: PCSrc=11.
  - jal: PCSrc=11, RegWre=1, RegDst=10, WrRegDSrc=0.
  - jr: PCSrc=10.
  - Undecoded opcode: PCSrc=00, no writes (NOP).
- EXE state, ALUOp per instruction:
  - add, addi, lw, sw: ADD.
  - sub, beq, bne: SUB.
  - and: AND.
  - or, ori: OR.
  - slt: SLT.
  - sll: SLL.
- EXE state, operand selects:
  - ALUSrcA=1 only for sll.
  - ALUSrcB=1 for addi, ori, lw, sw.
  - ExtSel=0 only for ori.
- Branch resolution: PCSrc=01 when (beq && zero) or (bne && !zero), else 00. zero is sampled combinationally in EXE and must be stable before the edge.
- MEM state: lw sets mRD=1; sw sets mWR=1.
- WB state:
  - RegWre=1, WrRegDSrc=1.
  - RegDst=01 for R-type, 00 for addi/ori/lw.
  - DBDataSrc=1 only for lw.
  - ALUOp and ALUSrc hold their EXE values through MEM/WB.
- Opcode and funct must not change except in IF; IR is loaded at the IF->ID edge.

Test Plan:
- Reset low mid-EXE of add -> state=000 asynchronously, RegWre=0, PCWre=0. Release Reset -> IF->ID->EXE->WB->IF; ALUOp=0000 in EXE, RegWre=1 and RegDst=01 in WB, PCWre pulses one cycle in WB.
- sub (funct 100010) with the ALU fed ReadData1=8, ReadData2=2 -> EXE drives ALUOp=0001, ALUSrcA=0, ALUSrcB=0; result 6, zero=0; 4-cycle instruction.
- beq with zero=1 -> EXE: ALUOp=0001, PCSrc=01, PCWre=1, next state IF (3 cycles). Same with zero=0 -> PCSrc=00.
- lw -> IF,ID,EXE(ALUSrcB=1, ExtSel=1, ALUOp=0000),MEM(mRD=1),WB(DBDataSrc=1, RegDst=00, RegWre=1). sw -> MEM has mWR=1 and PCWre=1, then IF (4 cycles).
- jal -> ID: PCSrc=11, RegWre=1, RegDst=10, WrRegDSrc=0, PCWre=1, next IF. sll -> EXE ALUSrcA=1, ALUOp=0010.
- opcode 111111 -> ID->HALT; state stays 111 for 20 cycles with PCWre=0, RegWre=0. Reset low -> IF.
